// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, instruction memory depth and the
// boot loader state type. Used by the loader, the instruction memory and the CPU.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned IMEM_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        DRAIN,
        RUN
    } loader_state_t;

endpackage : cpu_pkg

// File: rtl/imem_loader.sv
// Boot-time instruction loader. Zero-fills instruction memory, streams program
// words into the memory write port, then raises start_o to let the CPU run.
// A new load request while running reloads without a full reset.
//
// Ports:
//   clk_i, rst_i      clock (rising edge), synchronous active-high reset
//   load_i            one-cycle load request (honoured in IDLE and RUN)
//   word_valid_i      program word available
//   word_data_i       program word
//   word_last_i       marks the final program word
//   word_ready_o      loader accepts a word (valid && ready = transfer)
//   imem_we_o         instruction memory write enable (registered)
//   imem_addr_o       instruction memory word address (registered)
//   imem_data_o       instruction memory write data (registered)
//   start_o           CPU run enable
//   busy_o            clearing, loading or draining
//   count_o           words accepted in the current or last session
//   overflow_o        sticky: DEPTH words accepted without word_last_i
module imem_loader
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              word_valid_i,
    input  logic [XLEN-1:0]   word_data_i,
    input  logic              word_last_i,
    output logic              word_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [XLEN-1:0]   imem_data_o,
    output logic              start_o,
    output logic              busy_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;      // shared clear / load address counter
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   data_q, data_d;

    // State register and write-port flops
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state and write-port logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            IDLE, RUN: begin
                // First clear write is registered on entry; counter points at the next one
                if (load_i) begin
                    state_d = CLEAR;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    data_d  = '0;
                    cnt_d   = ADDR_W'(1);
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            CLEAR: begin
                // Counter wraps to zero once DEPTH clear writes have been issued
                if (cnt_q == '0) begin
                    state_d = LOAD;
                end else begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    data_d = '0;
                    cnt_d  = cnt_q + ADDR_W'(1);
                end
            end
            LOAD: begin
                if (word_valid_i) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    data_d  = word_data_i;
                    cnt_d   = cnt_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W + 1)'(1);
                    if (word_last_i || (cnt_q == LAST_ADDR)) begin
                        state_d = DRAIN;
                        ovf_d   = ~word_last_i;
                    end
                end
            end
            DRAIN: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign word_ready_o = (state_q == LOAD);
    assign start_o      = (state_q == RUN);
    assign busy_o       = (state_q == CLEAR) || (state_q == LOAD) || (state_q == DRAIN);
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_data_o  = data_q;
    assign count_o      = count_q;
    assign overflow_o   = ovf_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: instance 0 uses DEPTH=256, instance 1 uses DEPTH=8.
// A timestamp-based session model predicts every output each cycle.
module tb_imem_loader;

    logic clk;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic        rst   [2];
    logic        load  [2];
    logic        valid [2];
    logic        last  [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic        we    [2];
    logic        start [2];
    logic        busy  [2];
    logic        ovf   [2];
    logic [31:0] odata [2];
    logic [7:0]  addr0;
    logic [8:0]  cnt0;
    logic [2:0]  addr1;
    logic [3:0]  cnt1;
    logic [15:0] addr_w [2];
    logic [15:0] cnt_w  [2];

    assign addr_w[0] = 16'(addr0);
    assign addr_w[1] = 16'(addr1);
    assign cnt_w[0]  = 16'(cnt0);
    assign cnt_w[1]  = 16'(cnt1);

    imem_loader #(.DEPTH(256)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .load_i(load[0]),
        .word_valid_i(valid[0]), .word_data_i(wdata[0]), .word_last_i(last[0]),
        .word_ready_o(ready[0]), .imem_we_o(we[0]), .imem_addr_o(addr0),
        .imem_data_o(odata[0]), .start_o(start[0]), .busy_o(busy[0]),
        .count_o(cnt0), .overflow_o(ovf[0])
    );

    imem_loader #(.DEPTH(8)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .load_i(load[1]),
        .word_valid_i(valid[1]), .word_data_i(wdata[1]), .word_last_i(last[1]),
        .word_ready_o(ready[1]), .imem_we_o(we[1]), .imem_addr_o(addr1),
        .imem_data_o(odata[1]), .start_o(start[1]), .busy_o(busy[1]),
        .count_o(cnt1), .overflow_o(ovf[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // A session is described by its load cycle T and final-acceptance cycle F;
    // every output follows from where the current cycle sits relative to them.
    bit          sess [2]  = '{0, 0};
    bit          fin  [2]  = '{0, 0};
    int          t_ld [2]  = '{0, 0};
    int          t_fin[2]  = '{0, 0};
    int          k    [2]  = '{0, 0};
    bit          e_we [2]  = '{0, 0};
    bit          e_rdy[2]  = '{0, 0};
    bit          e_st [2]  = '{0, 0};
    bit          e_bsy[2]  = '{0, 0};
    bit          e_ovf[2]  = '{0, 0};
    bit          p_st [2]  = '{0, 0};
    int          e_adr[2]  = '{0, 0};
    int          e_cnt[2]  = '{0, 0};
    logic [31:0] e_dat[2];
    logic [31:0] exp_mem [2][256];
    logic [31:0] dut_mem [2][256];

    initial begin
        for (int i = 0; i < 2; i++) begin
            e_dat[i] = '0;
            for (int a = 0; a < 256; a++) begin
                exp_mem[i][a] = 32'hDEAD_BEEF;
                dut_mem[i][a] = 32'hDEAD_BEEF;
            end
        end
    end

    int          m_d, m_n, m_bad;
    bit          m_acc, m_we;
    int          m_adr;
    logic [31:0] m_dat;

    // Compare DUT against the model, then advance the model by one cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_d = (i == 0) ? 256 : 8;
            chk($sformatf("i%0d_ready", i), 64'(ready[i]), 64'(e_rdy[i]));
            chk($sformatf("i%0d_we", i),    64'(we[i]),    64'(e_we[i]));
            chk($sformatf("i%0d_start", i), 64'(start[i]), 64'(e_st[i]));
            chk($sformatf("i%0d_busy", i),  64'(busy[i]),  64'(e_bsy[i]));
            chk($sformatf("i%0d_count", i), 64'(cnt_w[i]), 64'(e_cnt[i]));
            chk($sformatf("i%0d_ovf", i),   64'(ovf[i]),   64'(e_ovf[i]));
            if (e_we[i]) begin
                chk($sformatf("i%0d_addr", i), 64'(addr_w[i]), 64'(e_adr[i]));
                chk($sformatf("i%0d_data", i), 64'(odata[i]),  64'(e_dat[i]));
            end
            if (we[i] === 1'b1) dut_mem[i][addr_w[i][7:0]] = odata[i];
            if (e_st[i] && !p_st[i]) begin
                m_bad = 0;
                for (int a = 0; a < m_d; a++)
                    if (dut_mem[i][a] !== exp_mem[i][a]) m_bad++;
                chk($sformatf("i%0d_mem_mismatches", i), 64'(m_bad), 64'd0);
            end
            p_st[i] = e_st[i];

            m_n = cyc + 1;
            if (rst[i]) begin
                sess[i] = 0; fin[i] = 0; k[i] = 0;
                e_we[i] = 0; e_rdy[i] = 0; e_st[i] = 0; e_bsy[i] = 0;
                e_ovf[i] = 0; e_cnt[i] = 0; e_adr[i] = 0; e_dat[i] = '0;
            end else begin
                m_acc = e_rdy[i] && valid[i];
                m_we  = 0;
                m_adr = e_adr[i];
                m_dat = e_dat[i];
                if (load[i] && !e_bsy[i]) begin
                    sess[i] = 1; fin[i] = 0; t_ld[i] = cyc; k[i] = 0;
                    e_cnt[i] = 0; e_ovf[i] = 0;
                    for (int a = 0; a < m_d; a++) exp_mem[i][a] = '0;
                end else if (m_acc) begin
                    m_we = 1; m_adr = k[i]; m_dat = wdata[i];
                    exp_mem[i][k[i]] = wdata[i];
                    k[i]++;
                    e_cnt[i] = k[i];
                    if (last[i] || k[i] == m_d) begin
                        fin[i] = 1; t_fin[i] = cyc; e_ovf[i] = !last[i];
                    end
                end
                if (!m_we && sess[i] && m_n >= t_ld[i] + 1 && m_n <= t_ld[i] + m_d) begin
                    m_we = 1; m_adr = m_n - t_ld[i] - 1; m_dat = '0;
                end
                e_we[i]  = m_we;
                e_adr[i] = m_adr;
                e_dat[i] = m_dat;
                e_bsy[i] = sess[i] && m_n >= t_ld[i] + 1 && (!fin[i] || m_n <= t_fin[i] + 1);
                e_st[i]  = sess[i] && fin[i] && m_n >= t_fin[i] + 2;
                e_rdy[i] = sess[i] && !fin[i] && m_n >= t_ld[i] + m_d + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_load(input int i, output int t);
        @(posedge clk); #1;
        load[i] = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        load[i] = 1'b0;
    endtask

    // mode: 0 valid every cycle, 1 alternate 1/0, 2 random
    task automatic send(input int i, input logic [31:0] words [16], input int n,
                        input bit last_on_end, input int mode, input int limit,
                        output int nacc);
        int  j = 0;
        int  w = 0;
        bit  tog = 1'b0;
        while (j < n && w < limit) begin
            @(posedge clk); #1;
            case (mode)
                0:       tog = 1'b1;
                1:       tog = !tog;
                default: tog = 1'($urandom_range(0, 1));
            endcase
            valid[i] = tog;
            wdata[i] = words[j];
            last[i]  = last_on_end && (j == n - 1);
            @(negedge clk);
            if (valid[i] && ready[i]) begin
                j++;
                w = 0;
            end else begin
                w++;
            end
        end
        @(posedge clk); #1;
        valid[i] = 1'b0;
        last[i]  = 1'b0;
        wdata[i] = $urandom;
        nacc = j;
    endtask

    task automatic wait_start(input int i, input int limit);
        int w = 0;
        while (start[i] !== 1'b1 && w < limit) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("i%0d_start_seen", i), 64'(start[i]), 64'd1);
    endtask

    task automatic at_cycle(input int x);
        @(negedge clk);
        while (cyc < x) @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    logic [31:0] prog [16];
    int          tl, nacc, nz;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; load[i] = 1'b0; valid[i] = 1'b0;
            last[i] = 1'b0; wdata[i] = '0;
        end
        for (int j = 0; j < 16; j++) prog[j] = '0;
        prog[0] = 32'h0050_0113;
        prog[1] = 32'h00A0_0193;
        prog[2] = 32'h0031_01B3;
        prog[3] = 32'h0000_0000;
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Idle with valid held high: nothing accepted, nothing written
        valid[0] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("idle_ready", 64'(ready[0]), 64'd0);
        chk("idle_we",    64'(we[0]),    64'd0);
        chk("idle_start", 64'(start[0]), 64'd0);
        chk("idle_count", 64'(cnt_w[0]), 64'd0);
        valid[0] = 1'b0;

        // Full clear then 4-word program, valid every cycle
        pulse_load(0, tl);
        fork
            send(0, prog, 4, 1'b1, 0, 400, nacc);
            begin
                at_cycle(tl + 1);
                chk("clr_first_we",   64'(we[0]),     64'd1);
                chk("clr_first_addr", 64'(addr_w[0]), 64'd0);
                chk("clr_first_busy", 64'(busy[0]),   64'd1);
                at_cycle(tl + 256);
                chk("clr_last_addr",  64'(addr_w[0]), 64'd255);
                at_cycle(tl + 257);
                chk("load_gap_we",    64'(we[0]),     64'd0);
                chk("load_ready",     64'(ready[0]),  64'd1);
                at_cycle(tl + 258);
                chk("load0_addr",     64'(addr_w[0]), 64'd0);
                chk("load0_data",     64'(odata[0]),  64'h0050_0113);
                at_cycle(tl + 261);
                chk("load3_addr",     64'(addr_w[0]), 64'd3);
                chk("load3_busy",     64'(busy[0]),   64'd1);
                at_cycle(tl + 262);
                chk("run_start",      64'(start[0]),  64'd1);
                chk("run_busy",       64'(busy[0]),   64'd0);
                chk("run_count",      64'(cnt_w[0]),  64'd4);
            end
        join
        chk("prog_accepted", 64'(nacc), 64'd4);
        nz = 0;
        for (int a = 4; a < 256; a++) if (dut_mem[0][a] !== 32'h0) nz++;
        chk("tail_zero", 64'(nz), 64'd0);

        // Reload from RUN with toggling valid
        pulse_load(0, tl);
        at_cycle(tl + 1);
        chk("reload_start_drop", 64'(start[0]),  64'd0);
        chk("reload_clr_addr",   64'(addr_w[0]), 64'd0);
        send(0, prog, 4, 1'b1, 1, 400, nacc);
        wait_start(0, 20);
        chk("toggle_count", 64'(cnt_w[0]), 64'd4);

        // Reload a 2-word program; old words must be zeroed
        prog[0] = 32'h1234_5678;
        prog[1] = 32'h9ABC_DEF0;
        pulse_load(0, tl);
        send(0, prog, 2, 1'b1, 0, 400, nacc);
        wait_start(0, 20);
        chk("two_count", 64'(cnt_w[0]), 64'd2);
        chk("two_ovf",   64'(ovf[0]),   64'd0);
        chk("two_old2",  64'(dut_mem[0][2]), 64'd0);

        // Reset mid-load after 2 of 4 words
        prog[2] = 32'h0031_01B3;
        pulse_load(0, tl);
        send(0, prog, 2, 1'b0, 0, 400, nacc);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("rst_we",    64'(we[0]),     64'd0);
        chk("rst_addr",  64'(addr_w[0]), 64'd0);
        chk("rst_data",  64'(odata[0]),  64'd0);
        chk("rst_busy",  64'(busy[0]),   64'd0);
        chk("rst_count", 64'(cnt_w[0]),  64'd0);
        pulse_load(0, tl);
        at_cycle(tl + 1);
        chk("restart_busy", 64'(busy[0]), 64'd1);
        send(0, prog, 4, 1'b1, 0, 400, nacc);
        wait_start(0, 20);

        // DEPTH=8 overflow: 10 words without last, only 8 taken
        for (int j = 0; j < 16; j++) prog[j] = 32'h100 + 32'(j);
        pulse_load(1, tl);
        send(1, prog, 10, 1'b0, 0, 30, nacc);
        chk("ovf_accepted", 64'(nacc), 64'd8);
        chk("ovf_flag",     64'(ovf[1]),   64'd1);
        chk("ovf_count",    64'(cnt_w[1]), 64'd8);
        chk("ovf_start",    64'(start[1]), 64'd1);

        // Randomised sessions on the small instance
        for (int it = 0; it < 40; it++) begin
            for (int j = 0; j < 16; j++) prog[j] = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk); #1;
                rst[1] = 1'b1;
                @(posedge clk); #1;
                rst[1] = 1'b0;
            end
            pulse_load(1, tl);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if ($urandom_range(0, 1) == 1) pulse_load(1, tl);
            send(1, prog, $urandom_range(1, 10), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2), 40, nacc);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_imem_loader
